id_ex_pipeline_reg: RTL
=======================

Name: id_ex_pipeline_reg

Overview:
ID/EX pipeline stage register with built-in load-use hazard detection.
- Captures the 9-bit control word from the base integer control unit, plus decoded operands and instruction fields from the ID stage.
- Presents them to EX one cycle later.
- Supports global stall (hold), flush (bubble) and automatic bubble insertion on a load-use dependency.

Parameters:
NB_CTRL, 9, control word width. Bit map: [0] RegWrite, [1] MemRead, [2] MemWrite, [3] ALUSrc, [4] MemToReg, [5] Branch, [6] Jump, [8:7] ALUOp.
NB_DATA, 32, register data / immediate / PC width.
NB_ADDR, 5, register index width.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_stall  input  1  global pipeline hold (debug/halt); stage keeps its contents.
i_flush  input  1  branch/jump redirect; next stage content is a bubble.
i_valid  input  1  ID holds a valid instruction.
i_ctrl  input  NB_CTRL  control word from the control unit.
i_pc  input  NB_DATA  PC of the ID instruction.
i_rs1_data  input  NB_DATA  register file read port 1.
i_rs2_data  input  NB_DATA  register file read port 2.
i_imm  input  NB_DATA  sign-extended immediate.
i_rs1_addr  input  NB_ADDR  source register 1 index.
i_rs2_addr  input  NB_ADDR  source register 2 index.
i_rd_addr  input  NB_ADDR  destination register index.
i_funct3  input  3  instruction funct3.
i_funct7b5  input  1  instruction bit 30.
o_valid  output  1  EX holds a valid instruction.
o_ctrl  output  NB_CTRL  registered control word.
o_pc, o_rs1_data, o_rs2_data, o_imm  output  NB_DATA  registered copies of the matching inputs.
o_rs1_addr, o_rs2_addr, o_rd_addr  output  NB_ADDR  registered copies of the matching inputs.
o_funct3  output  3  registered copy.
o_funct7b5  output  1  registered copy.
o_load_use_hazard  output  1  combinational; the ID instruction must be held (PC and IF/ID write disabled).

Behaviour:
- Reset: every registered output is 0, including o_valid and o_ctrl; o_load_use_hazard is therefore 0.
- Hazard (combinational):
  - o_load_use_hazard = o_valid & o_ctrl[1] & (o_rd_addr != 0) & i_valid & ((o_rd_addr == i_rs1_addr) | (o_rd_addr == i_rs2_addr)).
  - Asserted regardless of the ID opcode; false positives on unused rs2 are acceptable.
- Per-edge priority, highest first:
  1. i_rst: all registers cleared.
  2. i_flush: o_valid <= 0, o_ctrl <= 0; data and field registers are don't-care and are cleared to 0.
  3. i_stall: all registers hold.
  4. o_load_use_hazard: bubble inserted (o_valid <= 0, o_ctrl <= 0, other registers cleared). The upstream ID instruction is held externally and re-presented next cycle; the hazard then drops because EX holds the bubble.
  5. Otherwise load: o_valid <= i_valid; o_ctrl <= i_valid ? i_ctrl : 0; all fields loaded from inputs.
- Latency: 1 cycle from ID inputs to EX outputs.
- A bubble is architecturally a NOP: RegWrite, MemRead, MemWrite, Branch and Jump are all 0.
- Flush during a hazard: the flush wins. The result is a bubble, same as the hazard outcome.
- Stall during a hazard: the stage holds and the hazard stays asserted. The bubble is inserted on the first non-stalled edge.
- rd = x0 load: never raises a hazard.
- No internal state beyond the pipeline registers. Back-to-back loads are handled by repeated evaluation of the hazard equation.

Test Plan:
1. Reset: assert i_rst 2 cycles with i_valid=1, i_ctrl=9'h101 -> all outputs 0 during reset. First edge after release: o_valid=1, o_ctrl=9'h101.
2. Normal flow: drive ADD (i_ctrl=9'h101, rs1=3, rs2=4, rd=5, i_rs1_data=32'h10, i_pc=32'h40) -> next cycle outputs equal inputs, o_load_use_hazard=0.
3. Load-use: EX holds LW (o_ctrl=9'h01B, rd=5). ID presents rs1=5 -> o_load_use_hazard=1. Next edge: o_valid=0, o_ctrl=0. Re-presented ADD is loaded one cycle later.
4. Load to x0: EX LW with rd=0, ID rs2=0 -> o_load_use_hazard=0, normal load.
5. Flush vs hazard: hazard condition from scenario 3 plus i_flush=1 -> bubble. Next cycle with i_flush=0 and a new instruction -> loaded normally.
6. Stall: i_stall=1 for 3 cycles while inputs change -> outputs unchanged. With a concurrent hazard, o_load_use_hazard stays 1 throughout and the bubble appears on the first edge after i_stall drops.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: carries the decoded instruction from ID into EX and
// inserts a bubble on flush or on a load-use dependency against the EX load.
module id_ex_pipeline_reg #(
  parameter int NB_CTRL = 9,
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_rs1_data,
  input  logic [NB_DATA-1:0] i_rs2_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_ADDR-1:0] i_rs1_addr,
  input  logic [NB_ADDR-1:0] i_rs2_addr,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  input  logic [2:0]         i_funct3,
  input  logic               i_funct7b5,
  output logic               o_valid,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_rs1_data,
  output logic [NB_DATA-1:0] o_rs2_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_ADDR-1:0] o_rs1_addr,
  output logic [NB_ADDR-1:0] o_rs2_addr,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic [2:0]         o_funct3,
  output logic               o_funct7b5,
  output logic               o_load_use_hazard
);

  localparam int CTRL_MEMREAD = 1;

  logic               valid_q,  valid_d;
  logic [NB_CTRL-1:0] ctrl_q,   ctrl_d;
  logic [NB_DATA-1:0] pc_q,     pc_d;
  logic [NB_DATA-1:0] rs1_data_q, rs1_data_d;
  logic [NB_DATA-1:0] rs2_data_q, rs2_data_d;
  logic [NB_DATA-1:0] imm_q,    imm_d;
  logic [NB_ADDR-1:0] rs1_addr_q, rs1_addr_d;
  logic [NB_ADDR-1:0] rs2_addr_q, rs2_addr_d;
  logic [NB_ADDR-1:0] rd_addr_q,  rd_addr_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               funct7b5_q, funct7b5_d;
  logic               hazard_s;

  // Load in EX whose destination feeds the ID instruction; x0 never counts.
  always_comb begin
    hazard_s = valid_q & ctrl_q[CTRL_MEMREAD] & (rd_addr_q != {NB_ADDR{1'b0}}) & i_valid &
               ((rd_addr_q == i_rs1_addr) | (rd_addr_q == i_rs2_addr));
  end

  // Next-state selection: flush, then stall hold, then hazard bubble, then load.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    if (i_flush || (!i_stall && hazard_s)) begin
      valid_d    = 1'b0;
      ctrl_d     = {NB_CTRL{1'b0}};
      pc_d       = {NB_DATA{1'b0}};
      rs1_data_d = {NB_DATA{1'b0}};
      rs2_data_d = {NB_DATA{1'b0}};
      imm_d      = {NB_DATA{1'b0}};
      rs1_addr_d = {NB_ADDR{1'b0}};
      rs2_addr_d = {NB_ADDR{1'b0}};
      rd_addr_d  = {NB_ADDR{1'b0}};
      funct3_d   = 3'd0;
      funct7b5_d = 1'b0;
    end else if (i_stall) begin
      valid_d = valid_q;
    end else begin
      valid_d    = i_valid;
      ctrl_d     = i_valid ? i_ctrl : {NB_CTRL{1'b0}};
      pc_d       = i_pc;
      rs1_data_d = i_rs1_data;
      rs2_data_d = i_rs2_data;
      imm_d      = i_imm;
      rs1_addr_d = i_rs1_addr;
      rs2_addr_d = i_rs2_addr;
      rd_addr_d  = i_rd_addr;
      funct3_d   = i_funct3;
      funct7b5_d = i_funct7b5;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= {NB_CTRL{1'b0}};
      pc_q       <= {NB_DATA{1'b0}};
      rs1_data_q <= {NB_DATA{1'b0}};
      rs2_data_q <= {NB_DATA{1'b0}};
      imm_q      <= {NB_DATA{1'b0}};
      rs1_addr_q <= {NB_ADDR{1'b0}};
      rs2_addr_q <= {NB_ADDR{1'b0}};
      rd_addr_q  <= {NB_ADDR{1'b0}};
      funct3_q   <= 3'd0;
      funct7b5_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  assign o_valid           = valid_q;
  assign o_ctrl            = ctrl_q;
  assign o_pc              = pc_q;
  assign o_rs1_data        = rs1_data_q;
  assign o_rs2_data        = rs2_data_q;
  assign o_imm             = imm_q;
  assign o_rs1_addr        = rs1_addr_q;
  assign o_rs2_addr        = rs2_addr_q;
  assign o_rd_addr         = rd_addr_q;
  assign o_funct3          = funct3_q;
  assign o_funct7b5        = funct7b5_q;
  assign o_load_use_hazard = hazard_s;

endmodule
